// File: rtl/matrix_row_collector.sv
// matrix_row_collector
//   Drives one request strobe per row to a WIDTH-bit word producer and
//   collects DEPTH returned words into a packed DEPTH x WIDTH matrix. The
//   finished matrix is presented on a valid/ready handshake. A per-request
//   timeout zero-fills the row and raises a sticky error flag if the producer
//   never answers.
//
// Ports
//   i_clk          clock, rising edge
//   i_rst          asynchronous active-low reset
//   i_start        begin a collection (honoured in IDLE only)
//   o_c            one-cycle request strobe per row
//   i_cc           word returned by the producer
//   i_cc_valid     i_cc valid this cycle (used in WAIT only)
//   o_mat          packed matrix, row k at [k*WIDTH +: WIDTH]
//   o_mat_valid    matrix complete and held stable
//   i_mat_ready    downstream accepts the matrix
//   o_busy         high while in REQ or WAIT
//   o_timeout_err  sticky, set when any row of this collection timed out
module matrix_row_collector #(
  parameter int unsigned WIDTH   = 10,
  parameter int unsigned DEPTH   = 10,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  output logic                     o_c,
  input  logic [WIDTH-1:0]         i_cc,
  input  logic                     i_cc_valid,
  output logic [DEPTH*WIDTH-1:0]   o_mat,
  output logic                     o_mat_valid,
  input  logic                     i_mat_ready,
  output logic                     o_busy,
  output logic                     o_timeout_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DEPTH*WIDTH-1:0] mat_q, mat_d;
  logic                   c_q, c_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   err_q, err_d;

  logic                   row_wr;
  logic [WIDTH-1:0]       row_data;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    mat_d    = mat_q;
    c_d      = 1'b0;
    valid_d  = valid_q;
    busy_d   = busy_q;
    err_d    = err_q;
    row_wr   = 1'b0;
    row_data = '0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          mat_d   = '0;
          idx_d   = '0;
          err_d   = 1'b0;
          c_d     = 1'b1;
          busy_d  = 1'b1;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // A response on the timeout cycle wins over the timeout.
        if (i_cc_valid) begin
          row_wr   = 1'b1;
          row_data = i_cc;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d  = CNT_MAX;
          row_wr = 1'b1;
          err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end

        if (row_wr) begin
          if (idx_q == LAST_IDX) begin
            valid_d = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            c_d     = 1'b1;
            state_d = S_REQ;
          end
        end
      end

      S_DONE: begin
        if (i_mat_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (row_wr && (idx_q == IDX_W'(k))) begin
        mat_d[k*WIDTH +: WIDTH] = row_data;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      mat_q   <= '0;
      c_q     <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      mat_q   <= mat_d;
      c_q     <= c_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign o_c           = c_q;
  assign o_mat         = mat_q;
  assign o_mat_valid   = valid_q;
  assign o_busy        = busy_q;
  assign o_timeout_err = err_q;

endmodule
